// File: rtl/tlb_mem_pkg.sv
// Shared types and constants for the block-transfer master and its wait timer.
package tlb_mem_pkg;

   localparam int unsigned WORDS_PER_BLOCK = 4;
   localparam int unsigned BLOCK_W         = 128;
   localparam logic [9:0]  MEM_IDLE_ADDR   = 10'h3FC;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-word wait counter: tells the master when done may be honoured and when to give up.
module mem_wait_timer #(
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic settle_ok,
   output logic timeout
);

   localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_MIN = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES - 1);
   // Abort in the WAIT cycle whose increment makes the count reach CNT_MAX
   localparam logic [CNT_W-1:0] ABORT_AT   = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign settle_ok = (count >= SETTLE_MIN);
   assign timeout   = (count >= ABORT_AT);

endmodule

// File: rtl/mem_block_master.sv
// Moves a 4-word cache block to or from main memory, one change-triggered word access at a time.
module mem_block_master
   import tlb_mem_pkg::*;
#(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_write,
   input  logic [ADDR_W-1:0]                 req_addr,
   input  logic [WORDS_PER_BLOCK*DATA_W-1:0] req_wblock,
   output logic                              resp_valid,
   output logic                              resp_err,
   output logic [WORDS_PER_BLOCK*DATA_W-1:0] fill_block,
   output logic                              read_write_mem,
   output logic [ADDR_W-1:0]                 address_mem,
   output logic [DATA_W-1:0]                 write_data_mem,
   input  logic [DATA_W-1:0]                 read_data_mem,
   input  logic                              done
);

   localparam int unsigned BLK_W    = ADDR_W - 4;
   localparam logic [1:0]  LAST_OFF = 2'(WORDS_PER_BLOCK - 1);

   state_t                                 state;
   logic [BLK_W-1:0]                       blk;
   logic                                   wr;
   logic [1:0]                             off;
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] wblock;
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] fill_q;
   logic [1:0]                             nxt_off_c;
   logic                                   settle_ok;
   logic                                   timeout;
   logic                                   unused_addr_c;

   assign nxt_off_c     = off + 2'd1;
   assign fill_block    = fill_q;
   assign unused_addr_c = ^req_addr[3:0];

   mem_wait_timer #(
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == ISSUE),
      .inc       (state == WAIT),
      .settle_ok (settle_ok),
      .timeout   (timeout)
   );

   // Memory-port outputs are loaded on the edge into ISSUE so they hold through ISSUE+WAIT.
   // Word0 lives in the top lane, hence lane index LAST_OFF - off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         blk            <= '0;
         wr             <= 1'b0;
         off            <= '0;
         wblock         <= '0;
         fill_q         <= '0;
         read_write_mem <= 1'b0;
         address_mem    <= ADDR_W'(MEM_IDLE_ADDR);
         write_data_mem <= '0;
         resp_valid     <= 1'b0;
         resp_err       <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  blk            <= req_addr[ADDR_W-1:4];
                  wr             <= req_write;
                  wblock         <= req_wblock;
                  off            <= '0;
                  address_mem    <= {req_addr[ADDR_W-1:4], 4'b0000};
                  read_write_mem <= req_write;
                  write_data_mem <= req_write ? req_wblock[WORDS_PER_BLOCK*DATA_W-1 -: DATA_W] : '0;
                  resp_err       <= 1'b0;
                  req_ready      <= 1'b0;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (settle_ok && done) begin
                  if (!wr) begin
                     fill_q[LAST_OFF - off] <= read_data_mem;
                  end
                  if (off == LAST_OFF) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     state      <= RESP;
                  end else begin
                     off            <= nxt_off_c;
                     address_mem    <= {blk, nxt_off_c, 2'b00};
                     write_data_mem <= wr ? wblock[LAST_OFF - nxt_off_c] : '0;
                     state          <= ISSUE;
                  end
               end else if (timeout) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               // Park on offset 3 so the next offset-0 issue is always an address change
               address_mem[3:2] <= 2'b11;
               req_ready        <= 1'b1;
               state            <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
